// File: rtl/turf_cin_parallel_gen.sv
// rtl/turf_cin_parallel_gen.sv - TURF->TURFIO CIN command nybble generator
// Serializes 32-bit words MSB-nybble first in 8-cycle slots aligned to the sync_i frame.
module turf_cin_parallel_gen #(
  parameter logic [31:0] TRAIN_SEQUENCE = 32'hA55A6996,
  parameter logic [31:0] IDLE_WORD      = 32'h00000000
) (
  input  logic        sysclk_i,
  input  logic        sysclk_rstn_i,
  input  logic        sync_i,
  input  logic        train_i,
  input  logic [31:0] cmd_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  output logic [3:0]  cin_o,
  output logic [2:0]  nybble_idx_o,
  output logic        cmd_sent_o,
  output logic        train_active_o,
  output logic        misalign_o
);

  logic [31:0] shifter;
  logic [31:0] hold;
  logic        hold_full;

  logic        load;
  logic        accept;
  logic        send_hold;
  logic        hold_full_nxt;
  logic [31:0] next_word;

  assign load          = sync_i || (nybble_idx_o == 3'd7);
  assign accept        = cmd_valid_i && cmd_ready_o;
  assign send_hold     = load && !train_i && hold_full;
  // A word accepted on a load edge can never join that slot; it always lands in hold.
  assign hold_full_nxt = accept || (hold_full && !send_hold);
  assign next_word     = train_i   ? TRAIN_SEQUENCE :
                         hold_full ? hold           : IDLE_WORD;
  assign cin_o         = shifter[31:28];

  always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
    if (!sysclk_rstn_i) begin
      shifter        <= IDLE_WORD;
      nybble_idx_o   <= 3'd0;
      hold           <= 32'h0;
      hold_full      <= 1'b0;
      cmd_ready_o    <= 1'b0;
      cmd_sent_o     <= 1'b0;
      train_active_o <= 1'b0;
      misalign_o     <= 1'b0;
    end else begin
      if (load) begin
        nybble_idx_o   <= 3'd0;
        shifter        <= next_word;
        train_active_o <= train_i;
      end else begin
        nybble_idx_o <= nybble_idx_o + 3'd1;
        shifter      <= {shifter[27:0], 4'h0};
      end
      // A sync landing anywhere but the last nybble abandons the slot in flight.
      misalign_o  <= sync_i && (nybble_idx_o != 3'd7);
      cmd_sent_o  <= send_hold;
      if (accept)
        hold <= cmd_i;
      hold_full   <= hold_full_nxt;
      cmd_ready_o <= !hold_full_nxt;
    end
  end

endmodule

// File: doc/turf_cin_parallel_gen.md
Name: turf_cin_parallel_gen

Overview:
- SYSCLK-domain generator for the TURF→TURFIO CIN command stream; the transmit-side mirror of the TURFIO CIN parallel sync/lock logic.
- Serializes 32-bit command words into 4-bit nybbles, one per sysclk cycle, in 8-cycle word slots. Its output drives a 4:1 OSERDES (not part of this block).
- Sends the training sequence on demand so the far end can perform IDELAY, bitslip and lock.
- Aligns word slots to the 16-cycle frame marked by sync_i.

Parameters:
- TRAIN_SEQUENCE, 32'hA55A6996: word sent continuously while training.
- IDLE_WORD, 32'h00000000: word sent when there is no command and training is off.

Ports:
- sysclk_i  in  1  system clock; all logic runs on its rising edge.
- sysclk_rstn_i  in  1  asynchronous, active-low reset.
- sync_i  in  1  high for one cycle to mark frame cycle 0 of the 16-cycle frame.
- train_i  in  1  selects the training sequence at slot boundaries.
- cmd_i  in  32  command word.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  holding register empty; can accept a command.
- cin_o  out  4  nybble to the OSERDES, registered.
- nybble_idx_o  out  3  index (0-7) of the nybble currently on cin_o.
- cmd_sent_o  out  1  one-cycle pulse when a command word loads into the shifter.
- train_active_o  out  1  high while the slot currently being sent is TRAIN_SEQUENCE.
- misalign_o  out  1  one-cycle pulse when sync_i truncates a slot.

Behaviour:
- Interface: one clock, sysclk_i. Reset sysclk_rstn_i is asynchronous and active-low.
- Reset values:
  - cin_o=0, nybble_idx_o=0, shifter=IDLE_WORD.
  - holding register empty; cmd_ready_o=0.
  - cmd_sent_o, train_active_o and misalign_o all 0.
  - cmd_ready_o rises on the first edge after reset deassertion.
- Holding register (1 deep):
  - cmd_ready_o = hold empty, registered.
  - A command is accepted on an edge where cmd_valid_i && cmd_ready_o.
  - cmd_ready_o drops the next cycle.
  - It returns high the cycle after the held word moves into the shifter.
  - cmd_i may change freely after acceptance.
- Slot boundary (load edge): an edge where sync_i=1, or where nybble_idx_o=7.
  - At a load edge nybble_idx_o←0 and the shifter loads the next word.
  - Otherwise nybble_idx_o increments and the shifter shifts left by 4.
  - cin_o always shows shifter[31:28], so the MSB nybble is sent first.
- Alignment to sync_i:
  - Nybble 0 of a word appears on cin_o the cycle after the load edge. This fixed latency of 1 applies relative to sync_i.
  - Frame cycles 0 and 8 therefore start slots.
  - Before the first sync_i the slot counter free-runs from reset.
- Word selection at a load edge, in priority order:
  1. train_i=1 → TRAIN_SEQUENCE; train_active_o=1 for the slot. The holding register is kept untouched.
  2. hold full → held command; cmd_sent_o pulses and hold empties.
  3. otherwise → IDLE_WORD.
  - train_i is sampled only at load edges; a change mid-slot takes effect at the next boundary.
- Simultaneous events:
  - Accept and load on the same edge: the accepted word cannot be sent in that slot. It goes to hold and is sent in the following slot.
  - sync_i together with nybble_idx_o=7: a normal boundary; no misalign_o.
  - sync_i with nybble_idx_o≠7: realign.
    - The truncated word is abandoned, including a command word; it is not resent.
    - misalign_o pulses on the cycle after that edge.
    - The new slot loads normally.
- Reset mid-operation: the held command is discarded and output returns to reset values immediately, since reset is asynchronous.

Test Plan:
1. Reset then train_i=1, sync_i every 16 cycles → cin_o sequence A,5,5,A,6,9,9,6 repeating. Nybble 0 follows each sync by 1 cycle and again 8 cycles later. train_active_o=1; misalign_o never pulses.
2. train_i=0, no commands → cin_o=0 continuously; cmd_ready_o=1 from cycle 1 after reset.
3. Send cmd 32'h12345678 mid-slot → cmd_ready_o low the next cycle. At the next boundary cmd_sent_o pulses, then cin_o=1,2,…,8. cmd_ready_o returns high.
4. Command held while train_i=1 for 3 slots → three TRAIN slots, then the command is sent in the first slot after train_i drops. A second valid is not accepted until then.
5. sync_i asserted at nybble_idx_o=3 during command 32'hDEADBEEF → output D,E,A,D, then a new slot starts; misalign_o pulses once. The command is not resent; the next slot is IDLE_WORD or the next held command.
6. Assert sysclk_rstn_i low mid-slot with hold full → cin_o=0 and cmd_ready_o=0 immediately. After release, idle words and no cmd_sent_o pulse.
